// File: rtl/multiplicador_pkg.sv
// Shared types for the Booth multiplier: FSM states and Booth step encoding.
// No logic of its own; latency and backpressure are defined by the users.
// Early termination (MULT_EARLY_TERM_EN) does not change these types.
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SHIFT,
        DONE
    } estado_t;

    typedef enum logic [1:0] {
        NOP,
        ADD,
        SUB
    } op_booth_t;

    // Radix-2 Booth recoding of {Q[0], q_-1}
    function automatic op_booth_t decodifica_op(input logic [1:0] par);
        case (par)
            2'b10:   return SUB;
            2'b01:   return ADD;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_camino_datos.sv
// Booth A/Q/M/q_-1 datapath: add/sub unit, arithmetic shifter, step counter.
// One register update per cycle as commanded by the FSM; no backpressure.
// MULT_EARLY_TERM_EN adds a variable shift by the remaining step count.
module booth_camino_datos
    import multiplicador_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signo,
    input  logic [WIDTH-1:0]     multiplicando,
    input  logic [WIDTH-1:0]     multiplicador,
    input  logic                 carga_a,
    input  logic                 carga_q,
    input  logic                 carga_m,
    input  logic                 desplaza,
    input  logic                 resta,
`ifdef MULT_EARLY_TERM_EN
    input  logic                 salta,
    output logic                 sin_trabajo,
`endif
    output logic [1:0]           par,
    output logic                 ultimo,
    output logic [2*WIDTH-1:0]   producto
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_INI = CW'(N);

    logic [N-1:0]  a, q, m;
    logic          qm1;
    logic [CW-1:0] cnt;
    logic [N-1:0]  suma;
    logic [2*N:0]  v1, vs;

    assign suma = resta ? (a - m) : (a + m);
    assign v1   = {a[N-1], a, q};

`ifdef MULT_EARLY_TERM_EN
    logic [2*N:0] v;
    logic [N:0]   vec, mask;

    assign v  = {a, q, qm1};
    assign vs = salta ? ($signed(v) >>> cnt) : v1;

    // Remaining Booth pairs are all no-ops when the unconsumed bits are uniform
    always_comb begin
        vec         = {q, qm1};
        mask        = {(N+1){1'b1}} >> (CNT_INI - cnt);
        sin_trabajo = ((vec & mask) == '0) || ((vec & mask) == mask);
    end
`else
    assign vs = v1;
`endif

    assign par      = {q[0], qm1};
    assign ultimo   = (cnt == CW'(1));
    assign producto = vs[2*WIDTH:1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            a   <= '0;
            q   <= '0;
            m   <= '0;
            qm1 <= 1'b0;
            cnt <= '0;
        end else begin
            if (carga_m)
                m <= {signo & multiplicando[WIDTH-1], multiplicando};
            if (carga_q) begin
                q   <= {signo & multiplicador[WIDTH-1], multiplicador};
                qm1 <= 1'b0;
                cnt <= CNT_INI;
                a   <= '0;
            end else if (carga_a) begin
                a <= suma;
            end else if (desplaza) begin
                {a, q, qm1} <= vs;
`ifdef MULT_EARLY_TERM_EN
                cnt <= salta ? '0 : cnt - CW'(1);
`else
                cnt <= cnt - CW'(1);
`endif
            end
        end
    end

endmodule

// File: rtl/multiplicador_booth.sv
// Sequential radix-2 Booth multiplier, signed/unsigned selectable per request.
// Latency 2*WIDTH+2 cycles from accept to Fin; start is ignored while ocupado.
// MULT_EARLY_TERM_EN: skip trailing no-op steps (latency 2k+1), same results.
module multiplicador_booth
    import multiplicador_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signo,
    input  logic [WIDTH-1:0]     multiplicando,
    input  logic [WIDTH-1:0]     multiplicador,
    output logic [2*WIDTH-1:0]   resultado,
    output logic                 ocupado,
    output logic                 Fin
);

    estado_t             estado, estado_sig;
    op_booth_t           op;
    logic                carga_a, carga_q, carga_m, desplaza, resta, escribe;
    logic                ultimo;
    logic [1:0]          par;
    logic [2*WIDTH-1:0]  producto;
`ifdef MULT_EARLY_TERM_EN
    logic                salta, sin_trabajo;
`endif

    booth_camino_datos #(.WIDTH(WIDTH)) u_camino (
        .clk           (clk),
        .reset         (reset),
        .signo         (signo),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
        .carga_a       (carga_a),
        .carga_q       (carga_q),
        .carga_m       (carga_m),
        .desplaza      (desplaza),
        .resta         (resta),
`ifdef MULT_EARLY_TERM_EN
        .salta         (salta),
        .sin_trabajo   (sin_trabajo),
`endif
        .par           (par),
        .ultimo        (ultimo),
        .producto      (producto)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado    <= IDLE;
            resultado <= '0;
        end else begin
            estado <= estado_sig;
            if (escribe)
                resultado <= producto;
        end
    end

    always_comb begin
        estado_sig = estado;
        carga_a    = 1'b0;
        carga_q    = 1'b0;
        carga_m    = 1'b0;
        desplaza   = 1'b0;
        resta      = 1'b0;
        escribe    = 1'b0;
`ifdef MULT_EARLY_TERM_EN
        salta      = 1'b0;
`endif
        op         = decodifica_op(par);
        case (estado)
            IDLE: begin
                if (start) begin
                    carga_m    = 1'b1;
                    carga_q    = 1'b1;
                    estado_sig = CALC;
                end
            end
            CALC: begin
                carga_a    = (op != NOP);
                resta      = (op == SUB);
                estado_sig = SHIFT;
`ifdef MULT_EARLY_TERM_EN
                if (sin_trabajo) begin
                    carga_a    = 1'b0;
                    resta      = 1'b0;
                    desplaza   = 1'b1;
                    salta      = 1'b1;
                    escribe    = 1'b1;
                    estado_sig = DONE;
                end
`endif
            end
            SHIFT: begin
                desplaza = 1'b1;
                if (ultimo) begin
                    escribe    = 1'b1;
                    estado_sig = DONE;
                end else begin
                    estado_sig = CALC;
                end
            end
            DONE:    estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    assign ocupado = (estado != IDLE);
    assign Fin     = (estado == DONE);

endmodule

// File: tb/tb_multiplicador_booth.sv
// Bench for multiplicador_booth at WIDTH=3 and WIDTH=8 sharing clock and reset.
// Expected products are queued at issue time and checked when Fin is seen.
module tb_multiplicador_booth;

`ifdef MULT_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start3, signo3, start8, signo8;
    logic [2:0] m3, q3;
    logic [7:0] m8, q8;
    logic [5:0] res3;
    logic [15:0] res8;
    logic       ocu3, fin3, ocu8, fin8;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          dut;
        logic [15:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    multiplicador_booth #(.WIDTH(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .signo(signo3),
        .multiplicando(m3), .multiplicador(q3),
        .resultado(res3), .ocupado(ocu3), .Fin(fin3)
    );

    multiplicador_booth #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signo(signo8),
        .multiplicando(m8), .multiplicador(q8),
        .resultado(res8), .ocupado(ocu8), .Fin(fin8)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        logic [15:0] res_s[2], held[2];
        logic        ocu_s[2], fin_s[2], p_ocu[2], p_fin[2];
        int          t0[2];
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            held[i] = '0; p_ocu[i] = 1'b0; p_fin[i] = 1'b0; t0[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            res_s[0] = {10'b0, res3}; ocu_s[0] = ocu3; fin_s[0] = fin3;
            res_s[1] = res8;          ocu_s[1] = ocu8; fin_s[1] = fin8;
            if (!reset) begin
                for (int i = 0; i < 2; i++) begin
                    held[i] = '0; p_ocu[i] = 1'b0; p_fin[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (ocu_s[i] && !p_ocu[i]) begin
                        t0[i] = cyc;
                        check($sformatf("hold_dut%0d", i), res_s[i], held[i]);
                    end
                    if (fin_s[i]) begin
                        check($sformatf("fin_width_dut%0d", i), {15'b0, p_fin[i]}, 16'h0);
                        if (sb.size() == 0) begin
                            check($sformatf("unexpected_fin_dut%0d", i), 16'h1, 16'h0);
                        end else begin
                            e = sb.pop_front();
                            check("sb_dut_id", 16'(i), 16'(e.dut));
                            check($sformatf("product_dut%0d", i), res_s[i], e.res);
                            if (e.lat >= 0)
                                check($sformatf("latency_dut%0d", i), 16'(cyc - t0[i]), 16'(e.lat));
                            held[i] = e.res;
                        end
                    end
                    p_ocu[i] = ocu_s[i];
                    p_fin[i] = fin_s[i];
                end
            end
        end
    end

    task automatic wait_idle(input int d);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!(d == 0 ? ocu3 : ocu8))
                done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout_dut%0d: ocupado stuck, expected 0", d);
        end
    endtask

    task automatic run(input int d, input logic sg, input logic [7:0] m, input logic [7:0] q,
                       input logic [15:0] r, input int lat);
        exp_t e;
        e.dut = d; e.res = r; e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        if (d == 0) begin
            start3 = 1'b1; signo3 = sg; m3 = m[2:0]; q3 = q[2:0];
        end else begin
            start8 = 1'b1; signo8 = sg; m8 = m; q8 = q;
        end
        @(negedge clk);
        // Operands are scrambled after acceptance; the result must not care
        start3 = 1'b0; start8 = 1'b0;
        m3 = ~m3; q3 = ~q3; m8 = ~m8; q8 = 8'h5A ^ q8;
        wait_idle(d);
    endtask

    logic [2:0]  st_m[3], st_q[3];
    logic [5:0]  st_r[3];
    logic [7:0]  rm, rq;
    logic        rs;
    logic [15:0] rp;

    initial begin
        reset = 1'b0;
        start3 = 1'b0; signo3 = 1'b0; m3 = '0; q3 = '0;
        start8 = 1'b0; signo8 = 1'b0; m8 = '0; q8 = '0;
        repeat (3) @(negedge clk);
        check("rst_res3", {10'b0, res3}, 16'h0);
        check("rst_ocu3", {15'b0, ocu3}, 16'h0);
        check("rst_fin3", {15'b0, fin3}, 16'h0);
        check("rst_res8", res8, 16'h0);
        check("rst_ocu8", {15'b0, ocu8}, 16'h0);
        check("rst_fin8", {15'b0, fin8}, 16'h0);
        reset = 1'b1;

        // WIDTH=3 directed
        run(0, 1'b1, 8'h04, 8'h03, 16'h0034, ET ? 7 : 8);   // -4 * 3 = -12
        run(0, 1'b0, 8'h07, 8'h07, 16'h0031, 8);            // 7 * 7 = 49
        run(0, 1'b1, 8'h07, 8'h07, 16'h0001, ET ? 3 : 8);   // -1 * -1 = 1
        run(0, 1'b1, 8'h03, 8'h05, 16'h0037, ET ? -1 : 8);  // 3 * -3 = -9
        run(0, 1'b0, 8'h03, 8'h05, 16'h000F, ET ? -1 : 8);  // 3 * 5 = 15

        // WIDTH=8 directed
        run(1, 1'b1, 8'h80, 8'h80, 16'h4000, ET ? 17 : 18);
        run(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 18);
        run(1, 1'b0, 8'h80, 8'h80, 16'h4000, ET ? -1 : 18);
        run(1, 1'b1, 8'h80, 8'h7F, 16'hC080, ET ? -1 : 18);
        run(1, 1'b1, 8'hFF, 8'h7F, 16'hFF81, ET ? -1 : 18);
        run(1, 1'b0, 8'h55, 8'h00, 16'h0000, ET ? 1 : 18);
        run(1, 1'b1, 8'h7F, 8'h01, 16'h007F, ET ? 5 : 18);

        // start held high on WIDTH=3: IDLE, 8 CALC/SHIFT, DONE -> accepts every 10 cycles
        st_m[0] = 3'd6; st_q[0] = 3'd5; st_r[0] = 6'h1E;
        st_m[1] = 3'd3; st_q[1] = 3'd6; st_r[1] = 6'h12;
        st_m[2] = 3'd7; st_q[2] = 3'd7; st_r[2] = 6'h31;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.dut = 0; e.res = {10'b0, st_r[k]}; e.lat = 8;
            sb.push_back(e);
        end
        for (int j = 0; j <= 20; j++) begin
            @(negedge clk);
            start3 = 1'b1;
            if (j % 10 == 0) begin
                signo3 = 1'b0; m3 = st_m[j/10]; q3 = st_q[j/10];
            end else begin
                signo3 = 1'b1; m3 = 3'd1; q3 = 3'd2;
            end
        end
        @(negedge clk);
        start3 = 1'b0;
        wait_idle(0);

        // Reset while in SHIFT, with a start pending in the same cycle
        @(negedge clk);
        start8 = 1'b1; signo8 = 1'b1; m8 = 8'h12; q8 = 8'h34;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        reset = 1'b0; start8 = 1'b1;
        @(negedge clk);
        check("mid_rst_res8", res8, 16'h0);
        check("mid_rst_ocu8", {15'b0, ocu8}, 16'h0);
        check("mid_rst_fin8", {15'b0, fin8}, 16'h0);
        check("mid_rst_res3", {10'b0, res3}, 16'h0);
        reset = 1'b1; start8 = 1'b0;
        @(negedge clk);
        check("rst_start_dropped", {15'b0, ocu8}, 16'h0);
        run(1, 1'b1, 8'h12, 8'h34, 16'h03A8, ET ? 15 : 18);

        // Random sweep on WIDTH=8
        for (int k = 0; k < 6; k++) begin
            rm = 8'($urandom_range(0, 255));
            rq = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            if (rs)
                rp = 16'($signed(rm) * $signed(rq));
            else
                rp = {8'b0, rm} * {8'b0, rq};
            run(1, rs, rm, rq, rp, ET ? -1 : 18);
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++)
            @(negedge clk);
        check("sb_drained", 16'(sb.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
